result_writer_bram: RTL and testbench
=====================================

# result_writer_bram

Downstream stage of `data_mover_bram`: it consumes the eight per-core results (`result_0..7`) once the mover asserts `o_done`. It latches them, writes them as eight consecutive 32-bit words into a result BRAM through a single `true_dpbram` port, and tracks the argmax (class index and value) while writing. It reports completion with `o_idle`/`o_done` in the same style as the mover, so the top controller can chain mover → writer.

## Interface
Parameters:
- `DWIDTH`, 32, result word width and BRAM data width
- `AWIDTH`, 12, result BRAM address width
- `NUM_CORE`, 8, number of results per run (fixed at 8 for this revision)

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `i_run`  in  1  one-cycle start pulse; samples `i_result_*` and `i_base_addr`
- `i_base_addr`  in  AWIDTH  BRAM address of result 0
- `i_result_0` … `i_result_7`  in  DWIDTH each  per-core results, unsigned
- `o_idle`  out  1  high in IDLE only
- `o_write`  out  1  high in WRITE only
- `o_done`  out  1  one-cycle pulse in DONE
- `addr_b`  out  AWIDTH  BRAM port address
- `ce_b`  out  1  BRAM chip enable
- `we_b`  out  1  BRAM write enable
- `d_b`  out  DWIDTH  BRAM write data
- `o_max_idx`  out  3  index of the largest result from the last completed run
- `o_max_val`  out  DWIDTH  value of that result

## Operation
- FSM states: IDLE → WRITE → DONE → IDLE.
- IDLE:
  - `o_idle`=1.
  - If `i_run`=1 at a rising edge, latch all eight results into `res_q[0..7]` and `i_base_addr` into `base_q`.
  - Clear the write counter `cnt`=0 and go to WRITE.
- WRITE:
  - Each cycle drive `addr_b`=`base_q`+`cnt` (mod 2^AWIDTH), `d_b`=`res_q[cnt]`, `ce_b`=`we_b`=1.
  - Update the running max: `cur_idx`/`cur_val`.
  - `cnt` increments by 1; after `cnt`=7 go to DONE.
- DONE:
  - `o_done`=1 for exactly one cycle.
  - `o_max_idx`/`o_max_val` take `cur_idx`/`cur_val` on entry to DONE and hold until the next DONE or reset.
  - Then return to IDLE.
- Argmax rules:
  - Unsigned comparison.
  - Strictly-greater replaces the current max, so ties resolve to the lowest index.
  - All-zero results give idx 0, val 0.
- `i_run` outside IDLE is ignored. It is not queued and the latched data is unaffected.
- Address wrap: `base_q`+`cnt` overflows modulo 2^AWIDTH (e.g. base 4094 writes 4094, 4095, 0..5).
- `ce_b`/`we_b` are 0 in every state except WRITE; `addr_b`/`d_b` are 0 outside WRITE.

## Timing
- Reset values:
  - all outputs 0, except `o_idle`=1
  - state IDLE, `cnt`=0, `res_q`=0, `base_q`=0, `cur_*`=0
- Reset mid-run: the FSM returns to IDLE immediately (asynchronous). `ce_b`/`we_b` drop the same instant, no further writes occur, and `o_done` is not issued.
- Cycle 0 = edge where `i_run` is sampled in IDLE.
  - Cycles 1–8: WRITE; the BRAM write for result k occurs at edge k+1.
  - Cycle 9: DONE, `o_done`=1.
  - Cycle 10: IDLE, `o_idle`=1, next `i_run` accepted.
- Throughput: one run per 10 cycles.
- All outputs are registered or decoded from state and registers only. No combinational path from `i_result_*` to outputs.
- Input contract: `i_result_*` only needs to be valid at the sampling edge. The mover's results hold after its `o_done`, so the top may tie `i_run` to the mover's `o_done`.

## Structure
- Shared package entries:
  - state encoding (`S_IDLE`=2'd0, `S_WRITE`=2'd1, `S_DONE`=2'd2)
  - `NUM_CORE`=8 and `CNT_W`=3, shared with `data_mover_bram`
- Single flat module. No sub-module needed: the max compare is one comparator plus a mux.
- The bench pairs the block with one `true_dpbram` (port A = DUT, port B = bench readback).

## Test plan
- Results 10,20,…,80, base 0, `i_run` pulse:
  - ram[0..7]=10..80
  - `o_done` exactly at cycle 9
  - `o_max_idx`=7, `o_max_val`=80
- Results {5,99,3,99,0,0,0,1}, base 100:
  - ram[100..107] match
  - `o_max_idx`=1 (tie → lowest), `o_max_val`=99
- Base 4094, results 1..8:
  - writes land at 4094, 4095, 0..5
  - no write to any other address
- `i_run` re-pulsed at cycle 4 with different results:
  - ignored; memory holds the first set
  - single `o_done`, next run accepted only after `o_idle`
- `reset_n` low at cycle 5 of a run:
  - exactly 4 words written (edges 1–4)
  - `we_b`=0 immediately
  - outputs at reset values, no `o_done`
  - a subsequent run completes normally
- All results 0xFFFFFFFF except result_3=0:
  - `o_max_idx`=0, `o_max_val`=0xFFFFFFFF (unsigned compare)

Source files
------------

// File: rtl/result_writer_bram_pkg.sv
// Shared definitions for the result writer and its upstream data mover.
package result_writer_bram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int NUM_CORE = 8;
    localparam int CNT_W    = 3;

endpackage

// File: rtl/result_writer_bram.sv
// Latches eight per-core results, writes them to a result BRAM port as consecutive
// words, and reports the argmax (index and value) of the completed run.
module result_writer_bram #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int NUM_CORE = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_base_addr,
    input  logic [DWIDTH-1:0] i_result_0,
    input  logic [DWIDTH-1:0] i_result_1,
    input  logic [DWIDTH-1:0] i_result_2,
    input  logic [DWIDTH-1:0] i_result_3,
    input  logic [DWIDTH-1:0] i_result_4,
    input  logic [DWIDTH-1:0] i_result_5,
    input  logic [DWIDTH-1:0] i_result_6,
    input  logic [DWIDTH-1:0] i_result_7,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr_b,
    output logic              ce_b,
    output logic              we_b,
    output logic [DWIDTH-1:0] d_b,
    output logic [2:0]        o_max_idx,
    output logic [DWIDTH-1:0] o_max_val
);
    import result_writer_bram_pkg::*;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [DWIDTH-1:0]  res_q [NUM_CORE];
    logic [AWIDTH-1:0]  base_q;
    logic [2:0]         cur_idx;
    logic [DWIDTH-1:0]  cur_val;
    logic [2:0]         nxt_idx;
    logic [DWIDTH-1:0]  nxt_val;
    logic [DWIDTH-1:0]  wr_val;
    logic [DWIDTH-1:0]  results [NUM_CORE];

    assign results[0] = i_result_0;
    assign results[1] = i_result_1;
    assign results[2] = i_result_2;
    assign results[3] = i_result_3;
    assign results[4] = i_result_4;
    assign results[5] = i_result_5;
    assign results[6] = i_result_6;
    assign results[7] = i_result_7;

    assign wr_val = res_q[cnt];

    // Strictly greater keeps the earliest index on ties.
    always_comb begin
        nxt_idx = cur_idx;
        nxt_val = cur_val;
        if (wr_val > cur_val) begin
            nxt_idx = cnt;
            nxt_val = wr_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            base_q    <= '0;
            cur_idx   <= '0;
            cur_val   <= '0;
            o_max_idx <= '0;
            o_max_val <= '0;
            for (int i = 0; i < NUM_CORE; i++) res_q[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        for (int i = 0; i < NUM_CORE; i++) res_q[i] <= results[i];
                        base_q  <= i_base_addr;
                        cnt     <= '0;
                        cur_idx <= '0;
                        cur_val <= '0;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    cur_idx <= nxt_idx;
                    cur_val <= nxt_val;
                    cnt     <= cnt + 1'b1;
                    // The last compare lands on the same edge that enters DONE.
                    if (cnt == CNT_W'(NUM_CORE - 1)) begin
                        o_max_idx <= nxt_idx;
                        o_max_val <= nxt_val;
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_idle  = (state == S_IDLE);
    assign o_write = (state == S_WRITE);
    assign o_done  = (state == S_DONE);
    assign ce_b    = o_write;
    assign we_b    = o_write;
    assign addr_b  = o_write ? base_q + AWIDTH'(cnt) : '0;
    assign d_b     = o_write ? wr_val : '0;

endmodule

// File: tb/tb_result_writer_bram.sv
// Bench for result_writer_bram: a behavioural BRAM port with a write log, table-driven runs
// and hand-written sequences for re-pulse and mid-run reset.
module tb_result_writer_bram;

    typedef struct packed {
        logic [11:0]      base;
        logic [7:0][31:0] res;
        logic [2:0]       idx;
        logic [31:0]      val;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_run = 1'b0;
    logic [11:0]      base_addr = '0;
    logic [7:0][31:0] rin = '0;
    logic             o_idle, o_write, o_done, ce_b, we_b;
    logic [11:0]      addr_b;
    logic [31:0]      d_b, o_max_val;
    logic [2:0]       o_max_idx;

    logic [31:0] mem [0:4095];
    logic [11:0] wr_log [$];
    logic [31:0] wd_log [$];
    int          wr_total = 0;

    int checks = 0;
    int errors = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    result_writer_bram #(.DWIDTH(32), .AWIDTH(12), .NUM_CORE(8)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_base_addr(base_addr),
        .i_result_0(rin[0]), .i_result_1(rin[1]), .i_result_2(rin[2]), .i_result_3(rin[3]),
        .i_result_4(rin[4]), .i_result_5(rin[5]), .i_result_6(rin[6]), .i_result_7(rin[7]),
        .o_idle(o_idle), .o_write(o_write), .o_done(o_done),
        .addr_b(addr_b), .ce_b(ce_b), .we_b(we_b), .d_b(d_b),
        .o_max_idx(o_max_idx), .o_max_val(o_max_val)
    );

    always @(posedge clk) begin
        if (ce_b && we_b) begin
            mem[addr_b] <= d_b;
            wr_log.push_back(addr_b);
            wd_log.push_back(d_b);
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string tag, input int s, input int n, input logic [11:0] base,
                                input logic [7:0][31:0] res);
        logic [11:0] a;
        check({tag, "_wr_count"}, 64'(wr_total - s), 64'(n));
        for (int k = 0; k < n && (s + k) < wr_total; k++) begin
            a = base + 12'(k);
            check($sformatf("%s_addr%0d", tag, k), 64'(wr_log[s + k]), 64'(a));
            check($sformatf("%s_data%0d", tag, k), 64'(wd_log[s + k]), 64'(res[k]));
            check($sformatf("%s_ram%0d", tag, k), 64'(mem[a]), 64'(res[k]));
        end
    endtask

    // Sets inputs mid-cycle and pulses i_run across one rising edge (edge 0).
    task automatic start_run(input logic [11:0] base, input logic [7:0][31:0] res);
        @(negedge clk);
        base_addr = base;
        rin       = res;
        i_run     = 1'b1;
        @(posedge clk);
        #1 i_run = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s;
        int done_cyc;
        int dones;
        s = wr_total;
        done_cyc = -1;
        dones = 0;
        start_run(v.base, v.res);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (o_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(9));
        check({tag, "_done_count"}, 64'(dones), 64'(1));
        check({tag, "_idle_after"}, 64'(o_idle), 64'(1));
        check({tag, "_max_idx"}, 64'(o_max_idx), 64'(v.idx));
        check({tag, "_max_val"}, 64'(o_max_val), 64'(v.val));
        check_writes(tag, s, 8, v.base, v.res);
    endtask

    function automatic vec_t mk(input logic [11:0] base, input logic [7:0][31:0] res,
                                input logic [2:0] idx, input logic [31:0] val);
        vec_t v;
        v.base = base;
        v.res  = res;
        v.idx  = idx;
        v.val  = val;
        return v;
    endfunction

    initial begin
        logic [7:0][31:0] r;
        logic [7:0][31:0] ra;
        logic [7:0][31:0] rb;
        int s;
        int dones;

        for (int k = 0; k < 8; k++) r[k] = 32'(10 * (k + 1));
        vecs[0] = mk(12'd0, r, 3'd7, 32'd80);
        r = {32'd1, 32'd0, 32'd0, 32'd0, 32'd99, 32'd3, 32'd99, 32'd5};
        vecs[1] = mk(12'd100, r, 3'd1, 32'd99);
        for (int k = 0; k < 8; k++) r[k] = 32'(k + 1);
        vecs[2] = mk(12'd4094, r, 3'd7, 32'd8);
        for (int k = 0; k < 8; k++) r[k] = 32'hFFFF_FFFF;
        r[3] = 32'd0;
        vecs[3] = mk(12'd200, r, 3'd0, 32'hFFFF_FFFF);
        r = '0;
        vecs[4] = mk(12'd50, r, 3'd0, 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_idle", 64'(o_idle), 64'(1));
        check("rst_write", 64'(o_write), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_ce_we", 64'({ce_b, we_b}), 64'(0));
        check("rst_addr_data", 64'({addr_b, d_b}), 64'(0));
        check("rst_max", 64'({o_max_idx, o_max_val}), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Re-pulse during WRITE and again during DONE: both must be ignored.
        for (int k = 0; k < 8; k++) ra[k] = 32'(100 + k);
        for (int k = 0; k < 8; k++) rb[k] = 32'(900 + k);
        s = wr_total;
        dones = 0;
        start_run(12'd300, ra);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (k == 4) begin
                base_addr = 12'd700;
                rin       = rb;
                i_run     = 1'b1;
            end
            if (k == 5) i_run = 1'b0;
            if (k == 9) begin
                check("repulse_done_c9", 64'(o_done), 64'(1));
                i_run = 1'b1;
            end
            if (k == 10) begin
                check("repulse_idle_c10", 64'(o_idle), 64'(1));
                check("repulse_nowrite_c10", 64'(o_write), 64'(0));
                i_run = 1'b0;
            end
        end
        check("repulse_done_count", 64'(dones), 64'(1));
        check("repulse_max_idx", 64'(o_max_idx), 64'(7));
        check("repulse_max_val", 64'(o_max_val), 64'(107));
        check_writes("repulse", s, 8, 12'd300, ra);

        // Reset asserted during cycle 5, after the writes at edges 1-4.
        s = wr_total;
        dones = 0;
        start_run(12'd400, vecs[1].res);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_we", 64'(we_b), 64'(0));
        check("midrst_ce", 64'(ce_b), 64'(0));
        check("midrst_idle", 64'(o_idle), 64'(1));
        check("midrst_write", 64'(o_write), 64'(0));
        check("midrst_addr_data", 64'({addr_b, d_b}), 64'(0));
        check("midrst_max", 64'({o_max_idx, o_max_val}), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'(0));
        check_writes("midrst", s, 4, 12'd400, vecs[1].res);
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
